// File: rtl/pam4_fec_pkg.sv
// PAM4 FEC shared types, defaults and the Gray demap helper.
// Used by the frame assembler and its LRP tracker.
package pam4_fec_pkg;

  localparam int FRAME_SYMBOLS_DEF  = 64;
  localparam int LLR_RESOLUTION_DEF = 5;
  localparam int NUM_LRP_DEF        = 4;

  typedef enum logic [1:0] {
    SYM_P3 = 2'd0,
    SYM_P1 = 2'd1,
    SYM_M1 = 2'd2,
    SYM_M3 = 2'd3
  } pam4_sym_e;

  typedef enum logic [1:0] {
    BK_EMPTY,
    BK_FILLING,
    BK_FULL,
    BK_PRESENTED
  } bank_st_e;

  function automatic logic [1:0] gray_map(
    input pam4_sym_e s
  );
    logic [1:0] b;
    b = 2'b00;
    unique case (s)
      SYM_P3: b = 2'b10;
      SYM_P1: b = 2'b11;
      SYM_M1: b = 2'b01;
      SYM_M3: b = 2'b00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pam4_frame_assembler_if.sv
// Symbol input stream and frame output handshake bundle.
// master = slicer/decoder side, slave = frame assembler.
interface pam4_frame_assembler_if
  import pam4_fec_pkg::*;
#(
  parameter int FRAME_SYMBOLS  = FRAME_SYMBOLS_DEF,
  parameter int LLR_RESOLUTION = LLR_RESOLUTION_DEF,
  parameter int NUM_LRP        = NUM_LRP_DEF
);
  localparam int IDX_W = $clog2(2*FRAME_SYMBOLS);

  logic [1:0]                      symbol_in;
  logic [LLR_RESOLUTION-1:0]       llr_in;
  logic                            llr_sign_in;
  logic                            in_valid;
  logic [2*FRAME_SYMBOLS-1:0]      frame_bits;
  logic [NUM_LRP*IDX_W-1:0]        lrp_idx;
  logic [NUM_LRP*LLR_RESOLUTION-1:0] lrp_llr;
  logic [NUM_LRP-1:0]              lrp_mask;
  logic                            frame_valid;
  logic                            frame_ready;

  modport master (
    output symbol_in, llr_in, llr_sign_in,
    output in_valid, frame_ready,
    input  frame_bits, lrp_idx, lrp_llr,
    input  lrp_mask, frame_valid
  );

  modport slave (
    input  symbol_in, llr_in, llr_sign_in,
    input  in_valid, frame_ready,
    output frame_bits, lrp_idx, lrp_llr,
    output lrp_mask, frame_valid
  );

endinterface

// File: rtl/lrp_tracker.sv
// Keeps the NUM_LRP least-reliable bit positions of one frame.
// Unsorted entries; a strictly smaller llr evicts the current max.
module lrp_tracker #(
  parameter int NUM_LRP        = 4,
  parameter int LLR_RESOLUTION = 5,
  parameter int IDX_W          = 7
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              clear,
  input  logic                              update,
  input  logic [LLR_RESOLUTION-1:0]         llr,
  input  logic [IDX_W-1:0]                  idx,
  output logic [NUM_LRP*IDX_W-1:0]          lrp_idx,
  output logic [NUM_LRP*LLR_RESOLUTION-1:0] lrp_llr,
  output logic [NUM_LRP-1:0]                lrp_mask
);

  localparam int SEL_W = (NUM_LRP > 1) ? $clog2(NUM_LRP) : 1;

  typedef logic [LLR_RESOLUTION-1:0] llr_t;

  llr_t               llr_q  [NUM_LRP];
  logic [IDX_W-1:0]   idx_q  [NUM_LRP];
  logic [NUM_LRP-1:0] mask_q;

  llr_t               base_llr [NUM_LRP];
  logic [NUM_LRP-1:0] base_mask;
  logic               has_empty;
  logic [SEL_W-1:0]   empty_sel;
  logic [SEL_W-1:0]   max_sel;
  llr_t               max_llr;

  always_comb begin
    has_empty = 1'b0;
    empty_sel = '0;
    max_sel   = '0;
    base_mask = clear ? '0 : mask_q;
    for (int i = 0; i < NUM_LRP; i++) begin
      base_llr[i] = clear ? '1 : llr_q[i];
    end
    max_llr = base_llr[0];
    for (int i = NUM_LRP-1; i >= 0; i--) begin
      if (!base_mask[i]) begin
        has_empty = 1'b1;
        empty_sel = SEL_W'(i);
      end
    end
    // strict compare keeps the lowest entry on ties
    for (int i = 1; i < NUM_LRP; i++) begin
      if (base_llr[i] > max_llr) begin
        max_llr = base_llr[i];
        max_sel = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mask_q <= '0;
      for (int i = 0; i < NUM_LRP; i++) begin
        llr_q[i] <= '1;
        idx_q[i] <= '0;
      end
    end else if (update) begin
      mask_q <= base_mask;
      for (int i = 0; i < NUM_LRP; i++) begin
        llr_q[i] <= base_llr[i];
        idx_q[i] <= clear ? '0 : idx_q[i];
      end
      if (has_empty) begin
        mask_q[empty_sel] <= 1'b1;
        llr_q[empty_sel]  <= llr;
        idx_q[empty_sel]  <= idx;
      end else if (llr < max_llr) begin
        llr_q[max_sel] <= llr;
        idx_q[max_sel] <= idx;
      end
    end
  end

  always_comb begin
    lrp_mask = mask_q;
    for (int i = 0; i < NUM_LRP; i++) begin
      lrp_idx[i*IDX_W +: IDX_W] = idx_q[i];
      lrp_llr[i*LLR_RESOLUTION +: LLR_RESOLUTION] = llr_q[i];
    end
  end

endmodule

// File: rtl/pam4_frame_assembler.sv
// Gray-demaps sliced PAM4 symbols into ping-pong frame banks and
// presents each completed frame with its LRP list downstream.
module pam4_frame_assembler
  import pam4_fec_pkg::*;
#(
  parameter int FRAME_SYMBOLS  = FRAME_SYMBOLS_DEF,
  parameter int LLR_RESOLUTION = LLR_RESOLUTION_DEF,
  parameter int NUM_LRP        = NUM_LRP_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  output logic                    overflow,
  pam4_frame_assembler_if.slave   bus
);

  localparam int IDX_W = $clog2(2*FRAME_SYMBOLS);
  localparam int PTR_W =
    (FRAME_SYMBOLS > 1) ? $clog2(FRAME_SYMBOLS) : 1;
  localparam int FB = 2*FRAME_SYMBOLS;

  bank_st_e         st_q [2];
  bank_st_e         st_n [2];
  logic             wr_q, wr_n;
  logic             rd_q, rd_n;
  logic [PTR_W-1:0] ptr_q, ptr_n;
  logic             ovf_q, ovf_n;
  logic [FB-1:0]    bits_q [2];

  logic             take, writable, accept;
  logic             last, valid, hs;
  logic [1:0]       upd;
  logic [IDX_W-1:0] sym_idx;

  logic [NUM_LRP*IDX_W-1:0]          t_idx  [2];
  logic [NUM_LRP*LLR_RESOLUTION-1:0] t_llr  [2];
  logic [NUM_LRP-1:0]                t_mask [2];

  assign take     = rstn && en && bus.in_valid;
  assign writable = (st_q[wr_q] == BK_EMPTY) ||
                    (st_q[wr_q] == BK_FILLING);
  assign accept   = take && writable;
  assign last     = (ptr_q == PTR_W'(FRAME_SYMBOLS-1));
  assign valid    = (st_q[rd_q] == BK_PRESENTED);
  assign hs       = valid && bus.frame_ready;
  assign sym_idx  = IDX_W'({ptr_q, ~bus.llr_sign_in});

  always_comb begin
    st_n[0] = st_q[0];
    st_n[1] = st_q[1];
    wr_n    = wr_q;
    rd_n    = rd_q;
    ptr_n   = ptr_q;
    ovf_n   = ovf_q | (take && !writable);
    upd     = '0;
    upd[wr_q] = accept;
    if (hs) begin
      st_n[rd_q] = BK_EMPTY;
    end
    if (accept) begin
      if (last) begin
        st_n[wr_q] = BK_FULL;
        ptr_n      = '0;
        wr_n       = ~wr_q;
      end else begin
        st_n[wr_q] = BK_FILLING;
        ptr_n      = ptr_q + 1'b1;
      end
    end
    // the other bank holds the older frame, so it goes first
    if (!valid || hs) begin
      unique case (1'b1)
        (st_n[~rd_q] == BK_FULL): begin
          st_n[~rd_q] = BK_PRESENTED;
          rd_n        = ~rd_q;
        end
        (st_n[rd_q] == BK_FULL): begin
          st_n[rd_q] = BK_PRESENTED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q[0]   <= BK_EMPTY;
      st_q[1]   <= BK_EMPTY;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      ptr_q     <= '0;
      ovf_q     <= 1'b0;
      bits_q[0] <= '0;
      bits_q[1] <= '0;
    end else begin
      st_q[0] <= st_n[0];
      st_q[1] <= st_n[1];
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      ptr_q   <= ptr_n;
      ovf_q   <= ovf_n;
      if (accept) begin
        bits_q[wr_q][{ptr_q, 1'b0} +: 2] <=
          gray_map(pam4_sym_e'(bus.symbol_in));
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lrp_tracker #(
      .NUM_LRP        (NUM_LRP),
      .LLR_RESOLUTION (LLR_RESOLUTION),
      .IDX_W          (IDX_W)
    ) u_lrp (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (upd[b] && (ptr_q == '0)),
      .update   (upd[b]),
      .llr      (bus.llr_in),
      .idx      (sym_idx),
      .lrp_idx  (t_idx[b]),
      .lrp_llr  (t_llr[b]),
      .lrp_mask (t_mask[b])
    );
  end

  assign overflow        = ovf_q;
  assign bus.frame_valid = valid;
  assign bus.frame_bits  = valid ? bits_q[rd_q] : '0;
  assign bus.lrp_idx     = valid ? t_idx[rd_q]  : '0;
  assign bus.lrp_llr     = valid ? t_llr[rd_q]  : '0;
  assign bus.lrp_mask    = valid ? t_mask[rd_q] : '0;

endmodule
